mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port data RAM between the CPU control unit (port 0) and the program loader/debug port (port 1). Each requester issues single-word read or write accesses over a req/gnt handshake. The arbiter selects one requester per access using round-robin, drives the RAM from registered signals, and returns read data with a one-cycle valid pulse. An optional lock lets one port keep the RAM for an atomic sequence, such as a MOV read-then-write.

## Interface
- REG_SIZE, 8, address and data width
- LOCK_MAX, 4, maximum consecutive locked grants to one port before a forced release (only with MEM_ARB_LOCK_EN)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request; held until gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  REG_SIZE  access address
- wdata0 / wdata1  in  REG_SIZE  write data
- lock0 / lock1  in  1  keep ownership after this access (only with MEM_ARB_LOCK_EN)
- gnt0 / gnt1  out  1  one-cycle pulse: access issued to RAM this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid on rdata
- rdata  out  REG_SIZE  read data, shared by both ports, qualified by rvalid*
- mem_addr  out  REG_SIZE  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  REG_SIZE  RAM write data, registered
- mem_rdata  in  REG_SIZE  RAM read data; synchronous RAM, valid one cycle after mem_addr

## Operation
- States:
  - IDLE: sample requests, choose owner, latch that port's addr/we/wdata.
  - ACCESS: mem_* are driven from the latched values; gnt of the owner is high.
  - RESP: read only; rvalid of the owner is high, rdata = mem_rdata.
- Transitions:
  - IDLE→ACCESS if any eligible req, else stay in IDLE.
  - ACCESS→RESP if the access is a read.
  - ACCESS→IDLE if the access is a write.
  - RESP→IDLE always.
- Arbitration in IDLE:
  - Only one req high: that port wins.
  - Both high: the port ≠ last_q wins.
  - last_q updates to the winner on entry to ACCESS.
- Outside ACCESS: mem_we = 0, mem_addr and mem_wdata hold their last values.
- rdata = mem_rdata in RESP; 0 otherwise.
- Requesters drop req (or present the next access) in the cycle after gnt. The arbiter samples req again only after returning to IDLE.
- A req asserted during ACCESS or RESP waits; no access is ever dropped.
- Reset, asynchronous at any point including mid-access:
  - state = IDLE, last_q = 1 (port 0 wins the first tie).
  - All outputs 0: gnt*, rvalid*, rdata, mem_addr, mem_we, mem_wdata.
  - Lock state cleared.
  - An in-flight access is abandoned; no write is completed.

## Timing
- req sampled high in IDLE at cycle T:
  - gnt and mem_* driven at T+1.
  - Write lands in RAM at the end of T+1.
  - Read: rvalid and rdata at T+2.
- Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- Worst-case wait for a requesting port, no lock: one access of the other port, i.e. at most 3 cycles before its own ACCESS.
- gnt and rvalid are never high for both ports in the same cycle.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - If the owner's lock is high when its access is granted, the next IDLE considers only that port.
  - The other port's req is ignored until the owner's lock is low at a grant, or the owner has received LOCK_MAX consecutive grants.
  - The lock-run counter width is $clog2(LOCK_MAX+1). It resets on owner change or lock release.
  - When the owner's lock is still high but its req is low in IDLE, the arbiter waits; the other port stays blocked.
  - After a forced release, the other port wins the next tie.
- MEM_ARB_LOCK_EN undefined:
  - lock0 and lock1 ports are absent.
  - There is no counter; pure round-robin.

## Structure
- Shared cpu package holds `arb_state_t` (IDLE, ACCESS, RESP) and the port index constants `ARB_PORT_CU = 0` and `ARB_PORT_LD = 1`.
- No sub-module required. The round-robin select is small enough to stay inline.

## Test plan
- Single read: req0 with addr0 = 8'h10 and RAM[0x10] = 8'hA5 at T → gnt0 at T+1 with mem_addr = 8'h10, rvalid0 with rdata = 8'hA5 at T+2, nothing on port 1.
- Single write: req1, we1 = 1, addr1 = 8'h03, wdata1 = 8'h7E → gnt1 and mem_we = 1 with mem_addr = 8'h03, mem_wdata = 8'h7E for exactly one cycle; readback returns 8'h7E.
- Simultaneous requests out of reset: req0 and req1 both held → grants alternate 0, 1, 0, 1 over 4 accesses, and no cycle has both gnt high.
- Reset mid-read: rst low during ACCESS of a port-0 read → all outputs 0 immediately; after release, IDLE and no rvalid for the aborted read.
- Lock (MEM_ARB_LOCK_EN): port 0 does a locked read of 8'h20 then an unlocked write to 8'h21 while req1 is held high → both port-0 grants occur before gnt1.
- Lock limit (MEM_ARB_LOCK_EN, LOCK_MAX = 4): lock0 held permanently with req0 and req1 both high → 4 gnt0 pulses, then gnt1, then port 0 resumes.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: FSM state encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CU = 1'b0;
  localparam logic ARB_PORT_LD = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two requesters.
// Optional atomic lock with a bounded run length is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int REG_SIZE = 8
`ifdef MEM_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [REG_SIZE-1:0] addr0,
  input  logic [REG_SIZE-1:0] addr1,
  input  logic [REG_SIZE-1:0] wdata0,
  input  logic [REG_SIZE-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                lock0,
  input  logic                lock1,
`endif
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [REG_SIZE-1:0] rdata,
  output logic [REG_SIZE-1:0] mem_addr,
  output logic                mem_we,
  output logic [REG_SIZE-1:0] mem_wdata,
  input  logic [REG_SIZE-1:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_owner;
  logic       r_last;
  logic       w_elig0;
  logic       w_elig1;
  logic       w_any;
  logic       w_win;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  logic             r_lock_act;
  logic             r_lock_port;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lock_req;

  // While a lock is active only the locking port may be selected, even if it is idle.
  always_comb begin
    w_elig0    = req0 & (~r_lock_act | (r_lock_port == ARB_PORT_CU));
    w_elig1    = req1 & (~r_lock_act | (r_lock_port == ARB_PORT_LD));
    w_lock_req = (w_win == ARB_PORT_LD) ? lock1 : lock0;
    w_cnt_nxt  = r_lock_act ? (r_lock_cnt + CNT_W'(1)) : CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock_act  <= 1'b0;
      r_lock_port <= ARB_PORT_CU;
      r_lock_cnt  <= '0;
    end else if ((r_state == IDLE) && w_any) begin
      if (w_lock_req && (w_cnt_nxt < LOCK_MAX_C)) begin
        r_lock_act  <= 1'b1;
        r_lock_port <= w_win;
        r_lock_cnt  <= w_cnt_nxt;
      end else begin
        r_lock_act  <= 1'b0;
        r_lock_cnt  <= '0;
      end
    end
  end
`else
  always_comb begin
    w_elig0 = req0;
    w_elig1 = req1;
  end
`endif

  always_comb begin
    w_any = w_elig0 | w_elig1;
    if (w_elig0 && w_elig1)
      w_win = ~r_last;
    else if (w_elig1)
      w_win = ARB_PORT_LD;
    else
      w_win = ARB_PORT_CU;
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    rdata       = '0;
    case (r_state)
      IDLE: begin
        if (w_any)
          w_state_nxt = ACCESS;
      end
      ACCESS: begin
        gnt0        = (r_owner == ARB_PORT_CU);
        gnt1        = (r_owner == ARB_PORT_LD);
        w_state_nxt = mem_we ? IDLE : RESP;
      end
      RESP: begin
        rvalid0     = (r_owner == ARB_PORT_CU);
        rvalid1     = (r_owner == ARB_PORT_LD);
        rdata       = mem_rdata;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The mem_* registers double as the latched request; mem_we is only ever high in ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= ARB_PORT_CU;
      r_last    <= ARB_PORT_LD;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_any) begin
        r_owner   <= w_win;
        r_last    <= w_win;
        mem_addr  <= (w_win == ARB_PORT_LD) ? addr1 : addr0;
        mem_we    <= (w_win == ARB_PORT_LD) ? we1 : we0;
        mem_wdata <= (w_win == ARB_PORT_LD) ? wdata1 : wdata0;
      end else if (r_state == ACCESS) begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule
